ps2_multi_joypad: RTL and testbench

//  Parametrised PS/2 keyboard -> multi-joypad mapper; sits beside ps2_tranceiver and consumes its scan/cmd/ready interface.

---
 rtl/ps2_multi_joypad.sv | 229 ++++++++++++++++++++++
 tb/tb_ps2_multi_joypad.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_multi_joypad.sv
// rtl/ps2_multi_joypad.sv - PS/2 keyboard to multi-joypad mapper with keyboard init sequencer
// Runs the FF/ED/LED init handshake with ack timeout and retry, then decodes scancodes through a writable keymap.
module ps2_multi_joypad #(
  parameter int         NUM_PADS    = 2,
  parameter logic [7:0] LED_INIT    = 8'h00,
  parameter int         TIMEOUT_CYC = 5_000_000,
  parameter int         MAX_RETRY   = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_scan_val,
  input  logic [7:0]             i_scancode,
  input  logic                   i_ready,
  output logic                   o_cmd_val,
  output logic [7:0]             o_cmd,
  input  logic                   i_map_we,
  input  logic [5:0]             i_map_addr,
  input  logic [8:0]             i_map_data,
  output logic [NUM_PADS*10-1:0] o_jp_vector,
  output logic                   o_initdone,
  output logic                   o_init_err,
  output logic                   o_any_key
);

  localparam int NUM_KEYS = NUM_PADS * 10;
  localparam int TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RW       = $clog2(MAX_RETRY + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] BYTE_ACK    = 8'hFA;
  localparam logic [7:0] BYTE_RESEND = 8'hFE;
  localparam logic [7:0] BYTE_BAT    = 8'hAA;

  typedef enum logic [2:0] {
    ST_WAIT_RDY,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_BAT,
    ST_DONE,
    ST_ERR
  } state_t;

  // Which command the next ST_SEND issues; reset lands on the FF step.
  typedef enum logic [1:0] {
    STG_FF,
    STG_ED,
    STG_LED
  } stage_t;

  state_t        state, state_n;
  stage_t        stage, stage_n;
  logic [TW-1:0] timer, timer_n;
  logic [RW-1:0] retry, retry_n;
  logic          initdone_n;
  logic          hot_plug;
  logic          decode_en;

  logic                ext;
  logic                rel;
  logic [2:0]          skip;
  logic [NUM_KEYS-1:0] hit;

  function automatic logic [8:0] default_entry(input int k);
    case (k)
      0:       return 9'h01D;
      1:       return 9'h01B;
      2:       return 9'h01C;
      3:       return 9'h023;
      4:       return 9'h03B;
      5:       return 9'h042;
      6:       return 9'h03C;
      7:       return 9'h043;
      8:       return 9'h02A;
      9:       return 9'h032;
      10:      return 9'h175;
      11:      return 9'h172;
      12:      return 9'h16B;
      13:      return 9'h174;
      14:      return 9'h069;
      15:      return 9'h072;
      16:      return 9'h06B;
      17:      return 9'h073;
      18:      return 9'h070;
      19:      return 9'h071;
      default: return 9'h000;
    endcase
  endfunction

  // Entry p*10+b holds button b of pad p; button 0 (up) lands on the pad's top bit.
  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    for (genvar b = 0; b < 10; b++) begin : g_btn
      logic [8:0] entry;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          entry <= default_entry(p * 10 + b);
        end else if (i_map_we && i_map_addr == 6'(p * 10 + b)) begin
          entry <= i_map_data;
        end
      end

      assign hit[p*10+9-b] = (entry[7:0] != 8'h00) && (entry[7:0] == i_scancode) && (entry[8] == ext);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_WAIT_RDY;
      stage      <= STG_FF;
      timer      <= '0;
      retry      <= '0;
      o_initdone <= 1'b0;
    end else begin
      state      <= state_n;
      stage      <= stage_n;
      timer      <= timer_n;
      retry      <= retry_n;
      o_initdone <= initdone_n;
    end
  end

  always_comb begin
    state_n    = state;
    stage_n    = stage;
    timer_n    = '0;
    retry_n    = retry;
    initdone_n = o_initdone;
    hot_plug   = 1'b0;
    o_cmd_val  = 1'b0;
    o_cmd      = 8'hFF;
    case (state)
      ST_WAIT_RDY: begin
        if (i_ready) state_n = ST_SEND;
      end
      ST_SEND: begin
        o_cmd_val = 1'b1;
        case (stage)
          STG_FF:  o_cmd = CMD_RESET;
          STG_ED:  o_cmd = CMD_SET_LED;
          default: o_cmd = LED_INIT;
        endcase
        state_n = ST_WAIT_ACK;
      end
      ST_WAIT_ACK, ST_WAIT_BAT: begin
        timer_n = timer + 1'b1;
        if (state == ST_WAIT_ACK && i_scan_val && i_scancode == BYTE_ACK) begin
          timer_n = '0;
          case (stage)
            STG_FF: state_n = ST_WAIT_BAT;
            STG_ED: begin
              stage_n = STG_LED;
              state_n = ST_WAIT_RDY;
            end
            default: begin
              state_n    = ST_DONE;
              initdone_n = 1'b1;
            end
          endcase
        end else if (state == ST_WAIT_ACK && i_scan_val && i_scancode == BYTE_RESEND) begin
          timer_n = '0;
          state_n = ST_WAIT_RDY;
        end else if (state == ST_WAIT_BAT && i_scan_val && i_scancode == BYTE_BAT) begin
          timer_n = '0;
          stage_n = STG_ED;
          state_n = ST_WAIT_RDY;
        end else if (timer == TIMER_LAST) begin
          // A timeout restarts the whole sequence from FF, not just the stalled byte.
          timer_n = '0;
          retry_n = retry + 1'b1;
          if (retry == RETRY_LAST) begin
            state_n = ST_ERR;
          end else begin
            stage_n = STG_FF;
            state_n = ST_WAIT_RDY;
          end
        end
      end
      ST_DONE, ST_ERR: begin
        if (i_scan_val && i_scancode == BYTE_BAT) begin
          hot_plug = 1'b1;
          retry_n  = '0;
          stage_n  = STG_ED;
          state_n  = ST_WAIT_RDY;
        end
      end
      default: state_n = ST_WAIT_RDY;
    endcase
  end

  assign o_init_err = (state == ST_ERR);
  assign decode_en  = i_scan_val && (state == ST_DONE || state == ST_ERR) && !hot_plug;
  assign o_any_key  = |o_jp_vector;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_jp_vector <= '0;
      ext         <= 1'b0;
      rel         <= 1'b0;
      skip        <= '0;
    end else if (hot_plug) begin
      o_jp_vector <= '0;
      ext         <= 1'b0;
      rel         <= 1'b0;
      skip        <= '0;
    end else if (decode_en) begin
      if (skip != 3'd0) begin
        skip <= skip - 1'b1;
      end else begin
        case (i_scancode)
          8'hE0: ext  <= 1'b1;
          8'hF0: rel  <= 1'b1;
          8'hE1: skip <= 3'd7;
          8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
          end
          default: begin
            o_jp_vector <= rel ? (o_jp_vector & ~hit) : (o_jp_vector | hit);
            ext         <= 1'b0;
            rel         <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_multi_joypad.sv
// tb/tb_ps2_multi_joypad.sv - bench for ps2_multi_joypad
// Command scoreboard queue plus table-driven decode vectors and hand sequences for init corner cases.
`timescale 1ns/1ps
module tb_ps2_multi_joypad;

  localparam int         NP  = 2;
  localparam logic [7:0] LED = 8'h02;
  localparam int         TO  = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_val;
  logic [7:0]  scancode;
  logic        ready;
  logic        cmd_val;
  logic [7:0]  cmd;
  logic        map_we;
  logic [5:0]  map_addr;
  logic [8:0]  map_data;
  logic [19:0] jp_vector;
  logic        initdone;
  logic        init_err;
  logic        any_key;

  int         compared   = 0;
  int         mismatched = 0;
  logic [7:0] cmd_q[$];
  logic       prev_val = 1'b0;

  typedef struct {
    logic [23:0] bytes;
    int          n;
    logic [19:0] exp;
  } vec_t;

  vec_t tbl[20];

  always #5 clk = ~clk;

  ps2_multi_joypad #(
    .NUM_PADS(NP),
    .LED_INIT(LED),
    .TIMEOUT_CYC(TO),
    .MAX_RETRY(3)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_scan_val(scan_val),
    .i_scancode(scancode),
    .i_ready(ready),
    .o_cmd_val(cmd_val),
    .o_cmd(cmd),
    .i_map_we(map_we),
    .i_map_addr(map_addr),
    .i_map_data(map_data),
    .o_jp_vector(jp_vector),
    .o_initdone(initdone),
    .o_init_err(init_err),
    .o_any_key(any_key)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Command monitor: pops the scoreboard on every strobe and checks it lasts one cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (cmd_val) begin
        check("cmd_strobe_width", 32'(prev_val), 32'h0);
        if (cmd_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_cmd: got %0h want none", cmd);
        end else begin
          check("cmd_byte", 32'(cmd), 32'(cmd_q.pop_front()));
        end
      end
      prev_val = cmd_val;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    scan_val = 1'b0;
    scancode = 8'h00;
    map_we   = 1'b0;
    map_addr = 6'd0;
    map_data = 9'h000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    scan_val = 1'b1;
    scancode = b;
    tick();
    scan_val = 1'b0;
    scancode = 8'h00;
  endtask

  task automatic write_map(input logic [5:0] a, input logic [8:0] d);
    map_we   = 1'b1;
    map_addr = a;
    map_data = d;
    tick();
    map_we = 1'b0;
  endtask

  task automatic send_with_write(input logic [7:0] b, input logic [5:0] a, input logic [8:0] d);
    scan_val = 1'b1;
    scancode = b;
    map_we   = 1'b1;
    map_addr = a;
    map_data = d;
    tick();
    scan_val = 1'b0;
    map_we   = 1'b0;
  endtask

  task automatic wait_cmds(input int budget);
    int n = 0;
    while (cmd_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("cmd_wait_expired", 32'(cmd_q.size()), 32'h0);
    cmd_q.delete();
  endtask

  task automatic press(input string name, input logic [7:0] b, input logic [19:0] exp);
    send_byte(b);
    check(name, 32'(jp_vector), 32'(exp));
  endtask

  initial begin
    tbl[0]  = '{24'h1D0000, 1, 20'h00200};
    tbl[1]  = '{24'hF01D00, 2, 20'h00000};
    tbl[2]  = '{24'hE07500, 2, 20'h80000};
    tbl[3]  = '{24'h720000, 1, 20'h84000};
    tbl[4]  = '{24'hE0F075, 3, 20'h04000};
    tbl[5]  = '{24'hF07200, 2, 20'h00000};
    tbl[6]  = '{24'hE07200, 2, 20'h40000};
    tbl[7]  = '{24'hE0F072, 3, 20'h00000};
    tbl[8]  = '{24'h1D0000, 1, 20'h00200};
    tbl[9]  = '{24'h1D0000, 1, 20'h00200};
    tbl[10] = '{24'hFA1B00, 2, 20'h00300};
    tbl[11] = '{24'hE01B00, 2, 20'h00300};
    tbl[12] = '{24'hF01D00, 2, 20'h00100};
    tbl[13] = '{24'hF0FF1B, 3, 20'h00000};
    tbl[14] = '{24'h6B0000, 1, 20'h02000};
    tbl[15] = '{24'hE06B00, 2, 20'h22000};
    tbl[16] = '{24'hF06B00, 2, 20'h20000};
    tbl[17] = '{24'hE0F06B, 3, 20'h00000};
    tbl[18] = '{24'hEE0023, 3, 20'h00040};
    tbl[19] = '{24'hF0FE23, 3, 20'h00000};

    // T1: reset state and the full init handshake
    ready = 1'b0;
    do_reset();
    check("rst_cmd_val", 32'(cmd_val), 32'h0);
    check("rst_jp_vector", 32'(jp_vector), 32'h0);
    check("rst_initdone", 32'(initdone), 32'h0);
    check("rst_init_err", 32'(init_err), 32'h0);
    check("rst_any_key", 32'(any_key), 32'h0);
    repeat (5) tick();
    ready = 1'b1;
    cmd_q.push_back(8'hFF);
    wait_cmds(20);
    send_byte(8'hFA);
    send_byte(8'hAA);
    cmd_q.push_back(8'hED);
    wait_cmds(20);
    send_byte(8'hFA);
    cmd_q.push_back(LED);
    wait_cmds(20);
    check("initdone_before_last_ack", 32'(initdone), 32'h0);
    send_byte(8'hFA);
    check("initdone_after_init", 32'(initdone), 32'h1);

    // A held scancode without a strobe must not decode
    scancode = 8'h1D;
    repeat (2) tick();
    check("no_strobe_no_decode", 32'(jp_vector), 32'h0);

    // T2/T3: decode vectors
    for (int i = 0; i < 20; i++) begin
      logic [23:0] bs;
      bs = tbl[i].bytes;
      for (int j = 0; j < tbl[i].n; j++) send_byte(bs[23-8*j -: 8]);
      check($sformatf("vec[%0d]", i), 32'(jp_vector), 32'(tbl[i].exp));
      check($sformatf("any[%0d]", i), 32'(any_key), 32'(|tbl[i].exp));
    end

    // T5: runtime keymap writes
    write_map(6'd0, 9'h015);
    press("q_press", 8'h15, 20'h00200);
    press("w_unmapped", 8'h1D, 20'h00200);
    send_byte(8'hF0);
    press("q_release", 8'h15, 20'h00000);
    press("q_press2", 8'h15, 20'h00200);
    write_map(6'd0, 9'h01D);
    check("remap_keeps_state", 32'(jp_vector), 32'h00200);
    send_byte(8'hF0);
    press("old_key_release_nomatch", 8'h15, 20'h00200);
    send_byte(8'hF0);
    press("w_release", 8'h1D, 20'h00000);
    send_with_write(8'h15, 6'd0, 9'h015);
    check("same_cycle_old_entry", 32'(jp_vector), 32'h0);
    press("w_after_write", 8'h1D, 20'h00000);
    press("q_after_write", 8'h15, 20'h00200);
    send_byte(8'hF0);
    press("q_release2", 8'h15, 20'h00000);
    write_map(6'd40, 9'h02D);
    press("addr40_ignored", 8'h2D, 20'h00000);
    press("v_still_mapped", 8'h2A, 20'h00002);
    send_byte(8'hF0);
    press("v_release", 8'h2A, 20'h00000);
    write_map(6'd0, 9'h01D);

    // T6: hot-plug with keys held and a dangling E0, then Pause skip
    send_byte(8'h1D);
    send_byte(8'hE0);
    press("keys_held", 8'h75, 20'h80200);
    send_byte(8'hE0);
    send_byte(8'hAA);
    check("hotplug_clear", 32'(jp_vector), 32'h0);
    check("hotplug_any_key", 32'(any_key), 32'h0);
    cmd_q.push_back(8'hED);
    wait_cmds(20);
    press("init_bytes_not_decoded", 8'h1D, 20'h00000);
    send_byte(8'hFA);
    cmd_q.push_back(LED);
    wait_cmds(20);
    send_byte(8'hFA);
    press("ext_cleared_by_hotplug", 8'h75, 20'h00000);
    send_byte(8'hE1);
    send_byte(8'h1D);
    send_byte(8'h1B);
    send_byte(8'hF0);
    send_byte(8'hE0);
    send_byte(8'h3B);
    send_byte(8'h42);
    send_byte(8'h3C);
    check("pause_skipped", 32'(jp_vector), 32'h0);
    press("after_pause", 8'h1D, 20'h00200);
    send_byte(8'hF0);
    press("after_pause_release", 8'h1D, 20'h00000);

    // T4: mid-sequence reset, FE resend, timeouts to error, AA recovery
    do_reset();
    cmd_q.push_back(8'hFF);
    wait_cmds(20);
    do_reset();
    check("midseq_reset_initdone", 32'(initdone), 32'h0);
    cmd_q.push_back(8'hFF);
    wait_cmds(20);
    send_byte(8'hFE);
    cmd_q.push_back(8'hFF);
    wait_cmds(20);
    cmd_q.push_back(8'hFF);
    wait_cmds(TO + 20);
    cmd_q.push_back(8'hFF);
    wait_cmds(TO + 20);
    begin
      int n = 0;
      while (!init_err && n < 2 * TO) begin
        tick();
        n++;
      end
    end
    check("init_err_after_timeouts", 32'(init_err), 32'h1);
    check("initdone_after_timeouts", 32'(initdone), 32'h0);
    repeat (2 * TO) tick();
    check("err_stays", 32'(init_err), 32'h1);
    press("decode_in_err", 8'h1D, 20'h00200);
    send_byte(8'hAA);
    check("hotplug_clears_err", 32'(init_err), 32'h0);
    check("hotplug_clears_vec", 32'(jp_vector), 32'h0);
    cmd_q.push_back(8'hED);
    wait_cmds(20);
    send_byte(8'hFA);
    cmd_q.push_back(LED);
    wait_cmds(20);
    send_byte(8'hFA);
    check("initdone_after_recovery", 32'(initdone), 32'h1);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
